// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - coin-driven dice roller: 3 serial coin bits -> colour code.
// Optional DICE_VALUE_EN adds the registered face value and a one-cycle done pulse.
module dice_roller #(
  parameter logic [1:0] RED  = 2'b01,
  parameter logic [1:0] BLUE = 2'b10,
  parameter logic [1:0] NONE = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       coin,
  output logic [1:0] out
`ifdef DICE_VALUE_EN
  ,
  output logic [2:0] face_val,
  output logic [0:0] done
`endif
);

  typedef enum logic [1:0] {IDLE, B2, B1, B0} state_t;

  state_t     state, state_nxt;
  logic [2:0] face_sr, face_sr_nxt;
  logic [2:0] face_full;
  logic [1:0] out_nxt;

  // Faces 0 and 7 are not valid die faces and map to NONE.
  function automatic logic [1:0] colour(input logic [2:0] f);
    case (f)
      3'd1, 3'd3, 3'd5: colour = RED;
      3'd2, 3'd4, 3'd6: colour = BLUE;
      default:          colour = NONE;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    face_sr_nxt = face_sr;
    out_nxt     = out;
    face_full   = {face_sr[1:0], coin};
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = B2;
          face_sr_nxt = 3'd0;
          out_nxt     = NONE;
        end
      end
      B2: begin
        face_sr_nxt = face_full;
        state_nxt   = B1;
      end
      B1: begin
        face_sr_nxt = face_full;
        state_nxt   = B0;
      end
      B0: begin
        face_sr_nxt = face_full;
        out_nxt     = colour(face_full);
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      face_sr <= 3'd0;
      out     <= NONE;
    end else begin
      state   <= state_nxt;
      face_sr <= face_sr_nxt;
      out     <= out_nxt;
    end
  end

`ifdef DICE_VALUE_EN
  // Face value and done move on the same B0 edge that updates out.
  always_ff @(posedge clk) begin
    if (rst) begin
      face_val <= 3'd0;
      done     <= 1'b0;
    end else begin
      done <= (state == B0);
      if (state == B0)
        face_val <= face_full;
    end
  end
`endif

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - self-checking bench for dice_roller.
module tb_dice_roller;

  logic       clk = 1'b0;
  logic       rst, start, coin;
  logic [1:0] out;
`ifdef DICE_VALUE_EN
  logic [2:0] face_val;
  logic [0:0] done;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: bits still to collect and face gathered so far.
  int         m_left = 0;
  int         m_face = 0;
  logic [1:0] m_out  = 2'b00;

  typedef struct {
    logic [2:0] coins;
    logic [1:0] exp;
  } vec_t;
  vec_t vecs [8];

  dice_roller dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .coin  (coin),
    .out   (out)
`ifdef DICE_VALUE_EN
    ,
    .face_val (face_val),
    .done     (done)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] colour_of(input int f);
    if (f == 0 || f == 7) return 2'b00;
    else if (f % 2 == 1)  return 2'b01;
    else                  return 2'b10;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model with what the edge sampled, compare.
  task automatic step(input logic s, input logic c, input logic r);
    start = s; coin = c; rst = r;
    @(posedge clk);
    if (r) begin
      m_left = 0; m_face = 0; m_out = 2'b00;
    end else if (m_left == 0) begin
      if (s) begin
        m_left = 3; m_face = 0; m_out = 2'b00;
      end
    end else begin
      m_face = m_face * 2 + int'(c);
      m_left--;
      if (m_left == 0) m_out = colour_of(m_face);
    end
    #1;
    check("cycle", out, m_out);
  endtask

  task automatic roll(input logic [2:0] c);
    step(1'b1, $urandom_range(0, 1), 1'b0);
    step(1'b0, c[2], 1'b0);
    step(1'b0, c[1], 1'b0);
    step(1'b0, c[0], 1'b0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 2'b00}; vecs[1] = '{3'd1, 2'b01};
    vecs[2] = '{3'd2, 2'b10}; vecs[3] = '{3'd3, 2'b01};
    vecs[4] = '{3'd4, 2'b10}; vecs[5] = '{3'd5, 2'b01};
    vecs[6] = '{3'd6, 2'b10}; vecs[7] = '{3'd7, 2'b00};

    start = 1'b0; coin = 1'b0; rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("reset_out", out, 2'b00);
    for (int i = 0; i < 4; i++) step(1'b0, $urandom_range(0, 1), 1'b0);
    check("no_start_idle", out, 2'b00);

    for (int i = 0; i < 8; i++) begin
      roll(vecs[i].coins);
      check($sformatf("table_face%0d", vecs[i].coins), out, vecs[i].exp);
    end

    // Result holds while idle with coin toggling.
    roll(3'd3);
    for (int i = 0; i < 3; i++) step(1'b0, $urandom_range(0, 1), 1'b0);
    check("hold_idle", out, 2'b01);

    // Extra start during B1 is ignored.
    step(1'b1, 1'b0, 1'b0);
    check("accept_clears", out, 2'b00);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("start_in_b1", out, 2'b10);
`ifdef DICE_VALUE_EN
    checks++;
    if (face_val !== 3'd6 || done !== 1'b1) begin
      errors++;
      $display("FAIL face_val_done: face_val=%0d done=%b expected 6/1", face_val, done);
    end
`endif
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("back_to_idle", out, 2'b10);

    // Reset in B1 aborts, then a clean roll works.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("rst_mid_roll", out, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    check("rst_no_resume", out, 2'b00);
    roll(3'd5);
    check("after_rst_roll", out, 2'b01);

    // Held start: re-accepted the cycle right after B0.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("held_b0", out, 2'b10);
    step(1'b1, 1'b1, 1'b0);
    check("held_reaccept", out, 2'b00);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("held_second", out, 2'b01);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 39) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
